// File: rtl/can_pkg.sv
// Shared types and constants for the CAN 2.0A receive deframer.
package can_pkg;

  typedef enum logic [3:0] {
    ST_WAIT_IDLE,
    ST_IDLE,
    ST_ID,
    ST_RTR,
    ST_IDE,
    ST_R0,
    ST_DLC,
    ST_DATA,
    ST_CRC,
    ST_CRC_DEL,
    ST_ACK,
    ST_ACK_DEL,
    ST_EOF
  } can_state_e;

  localparam logic [14:0] CRC_POLY    = 15'h4599;
  localparam int          ID_W        = 11;
  localparam int          CRC_W       = 15;
  localparam int          EOF_BITS    = 7;
  localparam int          STUFF_LIMIT = 5;

  function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic b);
    return {crc[13:0], 1'b0} ^ ((b ^ crc[14]) ? CRC_POLY : 15'd0);
  endfunction

endpackage

// File: rtl/can_crc15.sv
// Serial CRC-15 over the destuffed frame bits; clear may coincide with the first bit.
module can_crc15
  import can_pkg::*;
(
  input  logic        CLOCK_SIGNAL_IN,
  input  logic        RESET,
  input  logic        clear,
  input  logic        enable,
  input  logic        crc_bit,
  output logic [14:0] crc
);

  logic [14:0] crc_base;

  assign crc_base = clear ? 15'd0 : crc;

  always_ff @(posedge CLOCK_SIGNAL_IN or posedge RESET) begin
    if (RESET) begin
      crc <= '0;
    end else if (enable) begin
      crc <= crc15_step(crc_base, crc_bit);
    end else if (clear) begin
      crc <= '0;
    end
  end

endmodule

// File: rtl/can_rx_deframer.sv
// CAN 2.0A receive deframer: destuffs, checks CRC/form, requests ACK and
// presents frames addressed to {7'b0, CAN_ADDR}.
//
//   state      | meaning
//   WAIT_IDLE  | counting recessive bits before the bus counts as idle
//   IDLE       | bus idle, waiting for a dominant SOF
//   ID         | 11 identifier bits
//   RTR        | remote request bit
//   IDE        | must be dominant (standard frame)
//   R0         | reserved bit
//   DLC        | 4 length bits
//   DATA       | 8*min(DLC,8) payload bits
//   CRC        | 15 received CRC bits (plus a trailing stuff bit if due)
//   CRC_DEL    | CRC delimiter, ACK request decided here
//   ACK        | ACK slot, level ignored
//   ACK_DEL    | ACK delimiter, CRC result reported here
//   EOF        | 7 recessive end-of-frame bits
module can_rx_deframer
  import can_pkg::*;
#(
  parameter int MAX_BYTES = 8,
  parameter int IDLE_BITS = 11
) (
  input  logic        CLOCK_SIGNAL_IN,
  input  logic        RESET,
  input  logic        baud_tick,
  input  logic        CAN_RX,
  input  logic        TXING,
  input  logic [3:0]  CAN_ADDR,
  output logic [10:0] rx_id,
  output logic [3:0]  rx_dlc,
  output logic        rx_rtr,
  output logic [63:0] rx_data,
  output logic        rx_valid,
  output logic        rx_error,
  output logic        ack_drive,
  output logic        busy
);

  can_state_e        state, state_nxt;
  logic [6:0]        bit_cnt, cnt_inc;
  logic [7:0]        idle_cnt, idle_inc;
  logic [2:0]        stuff_cnt, stuff_cnt_nxt;
  logic              last_bit;
  logic [ID_W-1:0]   id_sr;
  logic              rtr_sr;
  logic [3:0]        dlc_sr, dlc_nxt, dlc_eff;
  logic [63:0]       data_sr;
  logic [CRC_W-1:0]  crc_rx, crc_calc;
  logic              crc_ok, crc_match;
  logic              in_stuff, stuff_bit, stuff_err, data_bit;
  logic              frame_err, frame_done, accept;
  logic              sof, crc_clear, crc_en;

  assign in_stuff      = state inside {ST_ID, ST_RTR, ST_IDE, ST_R0, ST_DLC, ST_DATA, ST_CRC};
  assign stuff_bit     = in_stuff && (stuff_cnt == 3'(STUFF_LIMIT));
  assign stuff_err     = stuff_bit && (CAN_RX == last_bit);
  assign data_bit      = in_stuff && !stuff_bit;
  assign stuff_cnt_nxt = (CAN_RX == last_bit) ? stuff_cnt + 3'd1 : 3'd1;
  assign cnt_inc       = bit_cnt + 7'd1;
  assign idle_inc      = idle_cnt + 8'd1;
  assign dlc_nxt       = {dlc_sr[2:0], CAN_RX};
  assign dlc_eff       = (dlc_sr > 4'd8) ? 4'd8 : dlc_sr;
  assign crc_match     = (crc_rx == crc_calc);
  assign accept        = frame_done && (id_sr == {7'b0, CAN_ADDR});

  can_crc15 u_crc (
    .CLOCK_SIGNAL_IN (CLOCK_SIGNAL_IN),
    .RESET           (RESET),
    .clear           (crc_clear),
    .enable          (crc_en),
    .crc_bit         (CAN_RX),
    .crc             (crc_calc)
  );

  always_ff @(posedge CLOCK_SIGNAL_IN or posedge RESET) begin
    if (RESET) begin
      state <= ST_WAIT_IDLE;
    end else if (baud_tick) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    frame_err  = 1'b0;
    frame_done = 1'b0;
    case (state)
      ST_WAIT_IDLE: if (CAN_RX && idle_inc >= 8'(IDLE_BITS)) state_nxt = ST_IDLE;
      ST_IDLE:      if (!CAN_RX) state_nxt = ST_ID;
      ST_ID:        if (data_bit && bit_cnt == 7'(ID_W - 1)) state_nxt = ST_RTR;
      ST_RTR:       if (data_bit) state_nxt = ST_IDE;
      ST_IDE: begin
        if (data_bit) begin
          if (CAN_RX) frame_err = 1'b1;
          else        state_nxt = ST_R0;
        end
      end
      ST_R0:        if (data_bit) state_nxt = ST_DLC;
      ST_DLC: begin
        if (data_bit && bit_cnt == 7'd3)
          state_nxt = (rtr_sr || dlc_nxt == 4'd0) ? ST_CRC : ST_DATA;
      end
      ST_DATA:      if (data_bit && cnt_inc == {dlc_eff, 3'b000}) state_nxt = ST_CRC;
      ST_CRC: begin
        // a stuff bit owed after the last CRC bit is still consumed here
        if ((data_bit && bit_cnt == 7'(CRC_W - 1) && stuff_cnt_nxt != 3'(STUFF_LIMIT)) ||
            (stuff_bit && bit_cnt == 7'(CRC_W)))
          state_nxt = ST_CRC_DEL;
      end
      ST_CRC_DEL: begin
        if (!CAN_RX) frame_err = 1'b1;
        else         state_nxt = ST_ACK;
      end
      ST_ACK:       state_nxt = ST_ACK_DEL;
      ST_ACK_DEL: begin
        if (!CAN_RX || !crc_ok) frame_err = 1'b1;
        else                    state_nxt = ST_EOF;
      end
      ST_EOF: begin
        if (!CAN_RX) begin
          frame_err = 1'b1;
        end else if (bit_cnt == 7'(EOF_BITS - 1)) begin
          frame_done = 1'b1;
          state_nxt  = ST_WAIT_IDLE;
        end
      end
      default:      state_nxt = ST_WAIT_IDLE;
    endcase
    if (stuff_err) frame_err = 1'b1;
    if (frame_err) state_nxt = ST_WAIT_IDLE;
  end

  always_comb begin
    busy      = !(state inside {ST_WAIT_IDLE, ST_IDLE});
    sof       = (state == ST_IDLE) && !CAN_RX;
    crc_clear = baud_tick && sof;
    crc_en    = baud_tick && (sof ||
                (data_bit && state inside {ST_ID, ST_RTR, ST_IDE, ST_R0, ST_DLC, ST_DATA}));
  end

  always_ff @(posedge CLOCK_SIGNAL_IN or posedge RESET) begin
    if (RESET) begin
      bit_cnt   <= '0;
      idle_cnt  <= '0;
      stuff_cnt <= '0;
      last_bit  <= 1'b0;
      id_sr     <= '0;
      rtr_sr    <= 1'b0;
      dlc_sr    <= '0;
      data_sr   <= '0;
      crc_rx    <= '0;
      crc_ok    <= 1'b0;
      rx_id     <= '0;
      rx_dlc    <= '0;
      rx_rtr    <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_error  <= 1'b0;
      ack_drive <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
      if (baud_tick) begin
        rx_error  <= frame_err;
        ack_drive <= (state == ST_CRC_DEL) && CAN_RX && !TXING && crc_match;

        if (state_nxt != state)                bit_cnt <= '0;
        else if (data_bit || state == ST_EOF)  bit_cnt <= cnt_inc;

        if (sof) begin
          last_bit  <= 1'b0;
          stuff_cnt <= 3'd1;
          data_sr   <= '0;
        end else if (in_stuff) begin
          last_bit  <= CAN_RX;
          stuff_cnt <= stuff_cnt_nxt;
        end

        if (data_bit) begin
          case (state)
            ST_ID:   id_sr  <= {id_sr[ID_W-2:0], CAN_RX};
            ST_RTR:  rtr_sr <= CAN_RX;
            ST_DLC:  dlc_sr <= dlc_nxt;
            ST_DATA: if (int'(bit_cnt[5:3]) < MAX_BYTES) data_sr[{bit_cnt[5:3], ~bit_cnt[2:0]}] <= CAN_RX;
            ST_CRC:  crc_rx <= {crc_rx[CRC_W-2:0], CAN_RX};
            default: ;
          endcase
        end

        if (state == ST_CRC_DEL) crc_ok <= crc_match;

        // the seven EOF bits already count toward bus idle
        if (state_nxt == ST_WAIT_IDLE && state != ST_WAIT_IDLE)
          idle_cnt <= frame_err ? 8'd0 : 8'(EOF_BITS);
        else if (state == ST_WAIT_IDLE)
          idle_cnt <= CAN_RX ? idle_inc : 8'd0;

        if (accept) begin
          rx_valid <= 1'b1;
          rx_id    <= id_sr;
          rx_dlc   <= dlc_sr;
          rx_rtr   <= rtr_sr;
          rx_data  <= data_sr;
        end
      end
    end
  end

endmodule
